// File: rtl/bin_to_bcd_converter_if.sv
// Digit interface between the binary-to-BCD converter and its requester.
// slave = converter side, master = requester/display side.
interface bin_to_bcd_converter_if #(
    parameter int WIDTH = 14
);
    logic             start;
    logic [WIDTH-1:0] bin_in;
    logic [3:0]       units;
    logic [3:0]       tens;
    logic [3:0]       hundreds;
    logic [3:0]       thousands;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, bin_in,
        input  units, tens, hundreds, thousands, overflow, busy, done
    );

    modport slave (
        input  start, bin_in,
        output units, tens, hundreds, thousands, overflow, busy, done
    );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-add-3 converter: WIDTH-bit unsigned value to four held BCD digits,
// saturating to 9999 with an overflow flag.
module bin_to_bcd_converter #(
    parameter int WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    bin_to_bcd_converter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] bin_sr;
    logic [15:0]      acc;
    logic [CW-1:0]    cnt;
    logic             ovf_pend;

    logic [15:0]      acc_adj;
    logic [15:0]      acc_next;
    logic [WIDTH-1:0] bin_next;
    logic             in_ovf;
    logic             accept;

    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_next = {acc_adj[14:0], bin_sr[WIDTH-1]};
        bin_next = bin_sr << 1;
    end

    // Widened compare keeps the check legal for any WIDTH; constant-false below 14.
    assign in_ovf = 32'(bus.bin_in) > 32'd9999;
    assign accept = bus.start && (state == IDLE || state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bin_sr        <= '0;
            acc           <= '0;
            cnt           <= '0;
            ovf_pend      <= 1'b0;
            bus.units     <= '0;
            bus.tens      <= '0;
            bus.hundreds  <= '0;
            bus.thousands <= '0;
            bus.overflow  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else if (accept) begin
            bin_sr   <= bus.bin_in;
            acc      <= '0;
            cnt      <= CW'(WIDTH);
            ovf_pend <= in_ovf;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            state    <= SHIFT;
        end else begin
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
                SHIFT: begin
                    acc    <= acc_next;
                    bin_sr <= bin_next;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // Outputs load from the final shifted value so they are valid with done.
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        if (ovf_pend) begin
                            bus.units     <= 4'd9;
                            bus.tens      <= 4'd9;
                            bus.hundreds  <= 4'd9;
                            bus.thousands <= 4'd9;
                            bus.overflow  <= 1'b1;
                        end else begin
                            bus.units     <= acc_next[3:0];
                            bus.tens      <= acc_next[7:4];
                            bus.hundreds  <= acc_next[11:8];
                            bus.thousands <= acc_next[15:12];
                            bus.overflow  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: scoreboard of expected digits
// popped on each done pulse, plus per-scenario timing checks.
module tb_bin_to_bcd_converter;
    localparam int WIDTH = 14;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bin_to_bcd_converter_if #(.WIDTH(WIDTH)) bus ();

    bin_to_bcd_converter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [16:0] sb[$];

    function automatic logic [16:0] model(input int v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: scoreboard pop on done, digit hold between dones, BCD legality.
    logic [16:0] mon_got, mon_exp, mon_prev;
    logic        mon_prev_reset = 1'b1;
    always @(negedge clk) begin
        mon_got = {bus.overflow, bus.thousands, bus.hundreds, bus.tens, bus.units};
        if (bus.done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got %h, required no done pulse", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got ovf/digits %h, required %h", mon_got, mon_exp);
                end
            end
        end else if (!mon_prev_reset && !reset) begin
            checks++;
            if (mon_got !== mon_prev) begin
                errors++;
                $display("FAIL hold: outputs changed to %h without done, required %h", mon_got, mon_prev);
            end
        end
        if (!reset && !mon_prev_reset) begin
            checks++;
            if (bus.units > 4'd9 || bus.tens > 4'd9 || bus.hundreds > 4'd9 || bus.thousands > 4'd9) begin
                errors++;
                $display("FAIL bcd_legal: got digits %h, required each 0..9", mon_got[15:0]);
            end
        end
        mon_prev       = mon_got;
        mon_prev_reset = reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input int v);
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(v);
        sb.push_back(model(v));
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(1234);
        step();
        step();
        checks++;
        if ({bus.overflow, bus.thousands, bus.hundreds, bus.tens, bus.units, bus.busy, bus.done} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got %h, required 0",
                     {bus.overflow, bus.thousands, bus.hundreds, bus.tens, bus.units, bus.busy, bus.done});
        end
        bus.start = 1'b0;
        reset     = 1'b0;
        step();
    endtask

    task automatic test_latency();
        drive_start(1234);
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 1) bus.start = 1'b0;
            bus.bin_in = WIDTH'($urandom);
            checks++;
            if (bus.busy !== 1'(k <= 14) || bus.done !== 1'(k == 15)) begin
                errors++;
                $display("FAIL latency cycle N+%0d: got busy=%b done=%b, required busy=%b done=%b",
                         k, bus.busy, bus.done, 1'(k <= 14), 1'(k == 15));
            end
        end
        step();
    endtask

    task automatic test_values();
        int vals[5] = '{0, 9999, 12000, 16383, 42};
        foreach (vals[i]) begin
            drive_start(vals[i]);
            step();
            bus.start  = 1'b0;
            bus.bin_in = WIDTH'($urandom);
            for (int c = 0; c < 40 && bus.done !== 1'b1; c++) step();
            checks++;
            if (bus.done !== 1'b1) begin
                errors++;
                $display("FAIL values_timeout: got no done for %0d, required done", vals[i]);
            end
            step();
        end
    endtask

    task automatic test_ignore_start();
        drive_start(5678);
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 1) bus.start = 1'b0;
            if (k == 5) begin
                bus.start  = 1'b1;
                bus.bin_in = WIDTH'(1111);
            end
            if (k == 6) bus.start = 1'b0;
            checks++;
            if (bus.done !== 1'(k == 15)) begin
                errors++;
                $display("FAIL ignore_done cycle N+%0d: got done=%b, required %b", k, bus.done, 1'(k == 15));
            end
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if ({bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h5678 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: got digits %h done=%b, required 5678 done=0",
                         {bus.thousands, bus.hundreds, bus.tens, bus.units}, bus.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_done;
        drive_start(100);
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 1 || k == 16) bus.start = 1'b0;
            exp_busy = (k <= 14) || (k >= 16 && k <= 29);
            exp_done = (k == 15) || (k == 30);
            checks++;
            if (bus.busy !== exp_busy || bus.done !== exp_done) begin
                errors++;
                $display("FAIL b2b cycle N+%0d: got busy=%b done=%b, required busy=%b done=%b",
                         k, bus.busy, bus.done, exp_busy, exp_done);
            end
            if (k == 15) drive_start(2500);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive_start(321);
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 40 && bus.done !== 1'b1; c++) step();
        step();
        drive_start(4321);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        void'(sb.pop_back());
        step();
        reset = 1'b0;
        checks++;
        if ({bus.overflow, bus.thousands, bus.hundreds, bus.tens, bus.units, bus.busy, bus.done} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h, required 0",
                     {bus.overflow, bus.thousands, bus.hundreds, bus.tens, bus.units, bus.busy, bus.done});
        end
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort: got done=%b after abort, required 0", bus.done);
            end
        end
        drive_start(777);
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 40 && bus.done !== 1'b1; c++) step();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_timeout: got no done, required done");
        end
        step();
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.bin_in = '0;
        test_reset();
        test_latency();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Sequential shift-add-3 (double-dabble) converter from an unsigned binary ADC/count value to four BCD digits.
- It produces the units/tens/hundreds/thousands nibbles that the voltmeter's digit-multiplexing display state machine consumes.
- It is the producer end of that digit interface: a start/busy/done handshake loads a sample, and the result stays held and stable until the next conversion completes.

Parameters:
- WIDTH, 14, width of the binary input. Legal range 4..14. Values above 9999 are saturated.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous reset, active-high.
- start  input  1  request a conversion of bin_in. Honoured only while busy=0.
- bin_in  input  WIDTH  unsigned binary value, sampled in the cycle start is accepted.
- units  output  4  BCD digit 10^0, registered.
- tens  output  4  BCD digit 10^1, registered.
- hundreds  output  4  BCD digit 10^2, registered.
- thousands  output  4  BCD digit 10^3, registered.
- overflow  output  1  last completed conversion had bin_in > 9999, so the digits are saturated. Registered.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse: the digits and overflow have just been updated.

Behaviour:
- Reset (reset=1 at a rising edge):
  - state=IDLE.
  - units/tens/hundreds/thousands=0, overflow=0, busy=0, done=0.
  - Internal shift register and counter cleared.
  - Reset overrides start in the same cycle.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: capture bin_in into the binary shift register, clear the 16-bit BCD accumulator, load counter=WIDTH, latch ovf_pend = (bin_in > 9999), go to SHIFT.
- SHIFT, one bit per cycle, busy=1:
  - For each accumulator nibble ≥ 5, add 3 to that nibble. All four nibbles are corrected in parallel.
  - Then shift {accumulator, binary register} left by 1.
  - Decrement the counter. After the WIDTH-th shift, go to DONE.
  - start is ignored while in SHIFT.
- DONE, one cycle:
  - done=1, busy=0.
  - Output registers load on entry to DONE, so they are valid in the same cycle done=1.
  - If ovf_pend: units=tens=hundreds=thousands=9 and overflow=1. The accumulator contents are discarded.
  - Else: the outputs take the accumulator nibbles and overflow=0.
  - If start=1 in DONE, capture a new sample and go directly to SHIFT (back-to-back). Otherwise go to IDLE.
- Latency, for start accepted in cycle N:
  - busy=1 in cycles N+1 .. N+WIDTH.
  - done=1 and new digits visible in cycle N+WIDTH+1. For WIDTH=14 this is N+15.
  - Throughput: one conversion per WIDTH+1 cycles.
- Output holding:
  - The digit outputs change only on entry to DONE. They never show intermediate accumulator values, so the display does not flicker.
  - They hold across IDLE indefinitely.
- bin_in is don't-care except in the cycle start is accepted. Later changes do not affect the conversion in flight.
- Reset mid-SHIFT:
  - Conversion aborted with no done pulse.
  - Outputs return to 0, not to the previous result.
- Every output digit is always in 0..9. No illegal BCD codes under any condition.
- For WIDTH ≤ 13 the input cannot exceed 9999, so overflow stays 0. The comparison logic must still be legal and synthesisable.

Test Plan:
1. WIDTH=14; reset, then start with bin_in=1234 in cycle N -> busy high N+1..N+14; done=1 only in N+15 with thousands=1, hundreds=2, tens=3, units=4, overflow=0.
2. bin_in=0, then bin_in=9999 -> digits 0,0,0,0, then 9,9,9,9; overflow=0 both times.
3. bin_in=12000, then bin_in=16383 -> digits 9,9,9,9 with overflow=1 both times. A following bin_in=42 gives 0,0,4,2 with overflow=0.
4. Start with 5678; pulse start with bin_in=1111 at cycle N+5 -> second request ignored. Single done at N+15 with 5,6,7,8; digits stay 5,6,7,8 through IDLE.
5. Back-to-back: start with 100 at N, start held with 2500 in the DONE cycle N+15 -> done at N+15 shows 0,1,0,0; busy N+16..N+29; done at N+30 shows 2,5,0,0.
6. Prior result 0,3,2,1; start 4321, assert reset at cycle N+7 -> no done pulse; next cycle all digits=0, busy=0, overflow=0. A new start then converts correctly.
